// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit simple CPU: opcodes, ALU codes, sequencer states.
package cpu_pkg;

  localparam int PC_W_DEFAULT = 4;
  localparam int INSTR_W      = 8;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_LOAD = 3'd4;
  localparam logic [2:0] OP_JMP  = 3'd5;
  localparam logic [2:0] OP_JZ   = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  // ALU-class opcodes map onto the ALU control code; anything else defaults to ADD.
  function automatic logic [1:0] aluOpFor(input logic [2:0] opcode);
    case (opcode)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cpu_sequencer_pc_unit.sv
// pc_unit: program counter register with load and modulo-2^PC_W increment.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int          PC_W     = PC_W_DEFAULT,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            inc_i,
  input  logic            load_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Load wins over increment; the all-ones value rolls over to zero naturally.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pc_q <= PC_W'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute controller for the 8-bit CPU; owns PC and halt.
// Build macro CPU_SEQUENCER_SINGLE_STEP_EN holds each fetch until a step pulse.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int          PC_W     = PC_W_DEFAULT,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [INSTR_W-1:0] ir_out_o,
  input  logic [2:0]         opcode_in_i,
  input  logic [3:0]         imm_in_i,
  input  logic               sel_in_i,
  input  logic               acc_zero_i,
  output logic [1:0]         alu_op_o,
  output logic               operand_sel_o,
  output logic               acc_we_o,
  output logic               acc_load_o,
  output logic [PC_W-1:0]    pc_out_o,
  output logic               halted_o,
  input  logic               step_i
);

  state_e             state_q;
  state_e             state_d;
  logic [INSTR_W-1:0] ir_q;
  logic [2:0]         opcode_q;
  logic [3:0]         imm_q;
  logic               sel_q;
  logic               imemReq_q;
  logic               imemReq_d;
  logic               fetchAccept;
  logic               pcInc;
  logic               pcLoad;
  logic [PC_W-1:0]    pcValue;
  logic [PC_W-1:0]    jumpTarget;

  // The request is a register, so it drops at reset and never follows the ack combinationally.
  assign fetchAccept = (state_q == ST_FETCH) && imemReq_q && imem_ack_i;
  assign jumpTarget  = PC_W'(imm_q);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:   if (fetchAccept) state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: state_d = (opcode_q == OP_HALT) ? ST_HALT : ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    acc_we_o   = 1'b0;
    acc_load_o = 1'b0;
    alu_op_o   = ALU_ADD;
    halted_o   = 1'b0;
    pcInc      = 1'b0;
    pcLoad     = 1'b0;
    case (state_q)
      ST_EXECUTE: begin
        case (opcode_q)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            acc_we_o = 1'b1;
            alu_op_o = aluOpFor(opcode_q);
            pcInc    = 1'b1;
          end
          OP_LOAD: begin
            acc_we_o   = 1'b1;
            acc_load_o = 1'b1;
            pcInc      = 1'b1;
          end
          // Accumulator-indirect jumps are not supported and fall through as a NOP.
          OP_JMP: begin
            pcLoad = !sel_q;
            pcInc  = sel_q;
          end
          OP_JZ: begin
            pcLoad = !sel_q && acc_zero_i;
            pcInc  = !(!sel_q && acc_zero_i);
          end
          OP_HALT: begin
            pcInc = 1'b0;
          end
          default: begin
            pcInc = 1'b1;
          end
        endcase
      end
      ST_HALT: begin
        halted_o = 1'b1;
      end
      default: begin
        halted_o = 1'b0;
      end
    endcase
  end

`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
  // A step is only honoured while already sitting in FETCH; pulses elsewhere are lost.
  always_comb begin
    imemReq_d = 1'b0;
    if (state_d == ST_FETCH) begin
      imemReq_d = (state_q == ST_FETCH) && (imemReq_q || step_i);
    end
  end
`else
  logic unusedStep;
  assign unusedStep = step_i;

  always_comb begin
    imemReq_d = (state_d == ST_FETCH);
  end
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ir_q      <= '0;
      opcode_q  <= OP_ADD;
      imm_q     <= '0;
      sel_q     <= 1'b0;
      imemReq_q <= 1'b0;
    end else begin
      imemReq_q <= imemReq_d;
      if (fetchAccept) begin
        ir_q <= imem_data_i;
      end
      if (state_q == ST_DECODE) begin
        opcode_q <= opcode_in_i;
        imm_q    <= imm_in_i;
        sel_q    <= sel_in_i;
      end
    end
  end

  pc_unit #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) uPcUnit (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (pcInc),
    .load_i    (pcLoad),
    .target_i  (jumpTarget),
    .pc_o      (pcValue)
  );

  assign imem_req_o    = imemReq_q;
  assign imem_addr_o   = pcValue;
  assign pc_out_o      = pcValue;
  assign ir_out_o      = ir_q;
  assign operand_sel_o = sel_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: instruction-level reference model with a random-latency memory and decoder.
// Honours CPU_SEQUENCER_SINGLE_STEP_EN when the design is built with it.
module tb_cpu_sequencer;

  localparam int PC_W = 4;

  logic            clk = 1'b0;
  logic            resetN = 1'b1;
  logic            imemReq;
  logic [PC_W-1:0] imemAddr;
  logic            imemAck = 1'b0;
  logic [7:0]      imemData = 8'h00;
  logic [7:0]      irOut;
  logic [2:0]      opcodeIn;
  logic [3:0]      immIn;
  logic            selIn;
  logic            accZero = 1'b0;
  logic [1:0]      aluOp;
  logic            operandSel;
  logic            accWe;
  logic            accLoad;
  logic [PC_W-1:0] pcOut;
  logic            halted;
  logic            step = 1'b0;

  logic [7:0]      mem [16];
  logic [3:0]      modelPc;
  bit              firstAfterReset;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  // Decoder model: bit 7 operand select, bits 6:4 opcode, bits 3:0 immediate.
  assign opcodeIn = irOut[6:4];
  assign immIn    = irOut[3:0];
  assign selIn    = irOut[7];

  cpu_sequencer #(
    .PC_W     (PC_W),
    .RESET_PC (0)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (resetN),
    .imem_req_o    (imemReq),
    .imem_addr_o   (imemAddr),
    .imem_ack_i    (imemAck),
    .imem_data_i   (imemData),
    .ir_out_o      (irOut),
    .opcode_in_i   (opcodeIn),
    .imm_in_i      (immIn),
    .sel_in_i      (selIn),
    .acc_zero_i    (accZero),
    .alu_op_o      (aluOp),
    .operand_sel_o (operandSel),
    .acc_we_o      (accWe),
    .acc_load_o    (accLoad),
    .pc_out_o      (pcOut),
    .halted_o      (halted),
    .step_i        (step)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    imemAck = 1'b0;
    step    = 1'b0;
    #1 resetN = 1'b0;
    #1;
    checkOutput("rst_req", imemReq, 0);
    checkOutput("rst_pc", pcOut, 0);
    checkOutput("rst_ir", irOut, 0);
    checkOutput("rst_we", accWe, 0);
    checkOutput("rst_load", accLoad, 0);
    checkOutput("rst_alu", aluOp, 0);
    checkOutput("rst_sel", operandSel, 0);
    checkOutput("rst_halted", halted, 0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    modelPc = 4'd0;
    firstAfterReset = 1'b1;
  endtask

  // Called while the sequencer sits in FETCH: reset in the middle of it, then offer a stale ack.
  task automatic resetMidFetch();
    #2 resetN = 1'b0;
    #1;
    checkOutput("async_req_drop", imemReq, 0);
    checkOutput("async_pc", pcOut, 0);
    checkOutput("async_halted", halted, 0);
    imemAck  = 1'b1;
    imemData = 8'hFF;
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    imemAck = 1'b0;
    checkOutput("stale_ack_ir", irOut, 0);
    checkOutput("stale_ack_pc", pcOut, 0);
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    checkOutput("stale_ack_req", imemReq, 0);
`else
    checkOutput("stale_ack_req", imemReq, 1);
`endif
    modelPc = 4'd0;
    firstAfterReset = 1'b0;
  endtask

  // Runs one instruction at modelPc; azMode < 0 drives acc_zero randomly, else its value.
  task automatic applyStimulus(input int azMode, output bit hitHalt);
    logic [7:0] instr;
    logic [2:0] op;
    logic [3:0] imm;
    logic       sel;
    logic       az;
    logic [3:0] nextPc;
    int         waited;
    int         expWait;
    int         ackWait;

    hitHalt = 1'b0;
    waited  = 0;
    while (imemReq !== 1'b1 && waited < 20) begin
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
      step = (waited >= 2);
`endif
      @(negedge clk);
      waited++;
    end
    step = 1'b0;
    if (imemReq !== 1'b1) begin
      checkOutput("req_timeout", imemReq, 1);
      hitHalt = 1'b1;
      return;
    end
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    expWait = 3;
`else
    expWait = firstAfterReset ? 1 : 0;
`endif
    checkOutput("fetch_latency", waited, expWait);
    checkOutput("fetch_addr", imemAddr, modelPc);
    checkOutput("fetch_pc", pcOut, modelPc);

    instr = mem[modelPc];
    op    = instr[6:4];
    imm   = instr[3:0];
    sel   = instr[7];

    ackWait = $urandom_range(0, 3);
    repeat (ackWait) @(negedge clk);
    checkOutput("req_held", imemReq, 1);
    checkOutput("addr_held", imemAddr, modelPc);
    imemAck  = 1'b1;
    imemData = instr;
    @(negedge clk);
    imemAck  = 1'b0;
    imemData = 8'($urandom);

    checkOutput("decode_ir", irOut, instr);
    checkOutput("decode_req", imemReq, 0);
    checkOutput("decode_we", accWe, 0);
    imemAck = 1'($urandom);
    accZero = (azMode < 0) ? 1'($urandom) : azMode[0];
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    step = 1'($urandom);
`endif
    @(negedge clk);

    az = accZero;
    checkOutput("exec_we", accWe, (op <= 3'd4));
    checkOutput("exec_load", accLoad, (op == 3'd4));
    checkOutput("exec_sel", operandSel, sel);
    checkOutput("exec_req", imemReq, 0);
    if (op <= 3'd3) checkOutput("exec_alu_op", aluOp, op);
    case (op)
      3'd5:    nextPc = sel ? modelPc + 4'd1 : imm;
      3'd6:    nextPc = (!sel && az) ? imm : modelPc + 4'd1;
      3'd7:    nextPc = modelPc;
      default: nextPc = modelPc + 4'd1;
    endcase
    imemAck = 1'($urandom);
    @(negedge clk);
    imemAck = 1'b0;
    step    = 1'b0;

    checkOutput("next_pc", pcOut, nextPc);
    checkOutput("post_we", accWe, 0);
    checkOutput("halted", halted, (op == 3'd7));
    if (op == 3'd7) checkOutput("halt_req", imemReq, 0);
    modelPc = nextPc;
    firstAfterReset = 1'b0;
    hitHalt = (op == 3'd7);
  endtask

  task automatic checkHaltHold(input int cycles);
    repeat (cycles) begin
      imemAck = 1'($urandom);
      step    = 1'($urandom);
      @(negedge clk);
      checkOutput("hold_halted", halted, 1);
      checkOutput("hold_req", imemReq, 0);
      checkOutput("hold_we", accWe, 0);
      checkOutput("hold_pc", pcOut, modelPc);
    end
    imemAck = 1'b0;
    step    = 1'b0;
  endtask

  task automatic fillMem(input logic [7:0] filler);
    for (int i = 0; i < 16; i++) mem[i] = filler;
  endtask

  initial begin
    bit hit;
    int count;

    // LOAD 5 / ADD 3 / HALT
    fillMem(8'h70);
    mem[0] = 8'h45;
    mem[1] = 8'h03;
    mem[2] = 8'h70;
    resetDut();
    count = 0;
    hit   = 1'b0;
    while (!hit && count < 6) begin
      applyStimulus(-1, hit);
      count++;
    end
    checkOutput("p1_instr_count", count, 3);
    checkOutput("p1_final_pc", pcOut, 2);
    checkHaltHold(4);

    // Jumps, JZ not taken, and PC wrap from 15 to 0
    fillMem(8'h70);
    mem[0]  = 8'h53;
    mem[3]  = 8'h5A;
    mem[10] = 8'h62;
    mem[11] = 8'h5F;
    mem[15] = 8'h03;
    resetDut();
    for (int i = 0; i < 6; i++) applyStimulus(0, hit);
    checkOutput("p2_pc_after_wrap", modelPc, 3);

    // Reset mid-fetch, then JZ taken and accumulator-indirect forms acting as NOPs
    fillMem(8'h70);
    mem[0] = 8'h62;
    mem[2] = 8'hD5;
    mem[3] = 8'hE4;
    mem[4] = 8'h70;
    resetMidFetch();
    count = 0;
    hit   = 1'b0;
    while (!hit && count < 8) begin
      applyStimulus(1, hit);
      count++;
    end
    checkOutput("p3_instr_count", count, 4);
    checkHaltHold(2);

    // Random programs
    for (int prog = 0; prog < 20; prog++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      if (hit || (prog % 3) == 0) resetDut();
      else resetMidFetch();
      count = 0;
      hit   = 1'b0;
      while (!hit && count < 30) begin
        applyStimulus(-1, hit);
        count++;
      end
      if (hit) checkHaltHold(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got timeout expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
